// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: IDLE/WAIT/RESP handshake in front of a word array.
// Optional alignment checking is enabled with `define DMEM_RESPONDER_ALIGN_CHECK_EN.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h00000000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_dmem_addr,
   input  logic        i_dmem_ren,
   input  logic        i_dmem_wen,
   input  logic [31:0] i_dmem_wdata,
   input  logic [3:0]  i_dmem_mask,
   output logic        o_dmem_ready,
   output logic        o_dmem_valid,
   output logic [31:0] o_dmem_rdata,
   output logic        o_dmem_err
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        accept;

   logic [31:0] req_addr, req_wdata;
   logic        req_ren, req_wen;
   logic [3:0]  req_mask;

   logic [31:0] mem [DEPTH_WORDS];

   // The request being decoded: live inputs on the accept cycle, latched copy afterwards.
   // This lets LATENCY=1 respond straight from the accept edge.
   logic [31:0] cur_addr;
   logic        cur_ren, cur_wen;
   logic [3:0]  cur_mask;
   logic [31:0] off_w;
   logic [AW-1:0] idx;
   logic        oob, misalign, cur_err;
   logic [31:0] lane_m, rdata_n;

   always_comb begin
      if (state == S_IDLE) begin
         cur_addr = i_dmem_addr;
         cur_ren  = i_dmem_ren;
         cur_wen  = i_dmem_wen;
         cur_mask = i_dmem_mask;
      end else begin
         cur_addr = req_addr;
         cur_ren  = req_ren;
         cur_wen  = req_wen;
         cur_mask = req_mask;
      end
   end

   always_comb begin
      off_w = (cur_addr - BASE_ADDR) >> 2;
      idx   = off_w[AW-1:0];
      oob   = (off_w >= 32'(DEPTH_WORDS));
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
      misalign = (cur_addr[1:0] != 2'b00) ||
                 !(cur_mask inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0011, 4'b1100, 4'b1111});
`else
      misalign = 1'b0;
`endif
      cur_err = oob | (cur_ren & cur_wen) | misalign;
      lane_m  = {{8{cur_mask[3]}}, {8{cur_mask[2]}}, {8{cur_mask[1]}}, {8{cur_mask[0]}}};
      rdata_n = 32'h0;
      if (state_n == S_RESP && cur_ren && !cur_err)
         rdata_n = mem[idx] & lane_m;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      case (state)
         S_IDLE: begin
            if (o_dmem_ready && (i_dmem_ren || i_dmem_wen)) begin
               accept  = 1'b1;
               cnt_n   = CNT_INIT;
               state_n = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) state_n = S_RESP;
         end
         S_RESP: begin
            cnt_n   = 4'd0;
            state_n = S_IDLE;
         end
         default: begin
            cnt_n   = 4'd0;
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_IDLE;
         cnt          <= 4'd0;
         req_addr     <= 32'h0;
         req_wdata    <= 32'h0;
         req_ren      <= 1'b0;
         req_wen      <= 1'b0;
         req_mask     <= 4'h0;
         o_dmem_ready <= 1'b0;
         o_dmem_valid <= 1'b0;
         o_dmem_rdata <= 32'h0;
         o_dmem_err   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            req_addr  <= i_dmem_addr;
            req_wdata <= i_dmem_wdata;
            req_ren   <= i_dmem_ren;
            req_wen   <= i_dmem_wen;
            req_mask  <= i_dmem_mask;
         end
         o_dmem_ready <= (state_n == S_IDLE);
         o_dmem_valid <= (state_n == S_RESP);
         o_dmem_rdata <= rdata_n;
         o_dmem_err   <= (state_n == S_RESP) && cur_err;
      end
   end

   // Storage is never reset; the write commits on the edge that ends RESP.
   always_ff @(posedge i_clk) begin
      if (!i_rst && state == S_RESP && req_wen && !req_ren && !o_dmem_err) begin
         for (int b = 0; b < 4; b++)
            if (req_mask[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboarded requests, latency and handshake checks.
module tb_dmem_responder;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 1024;

   logic        clk, rst;
   logic [31:0] addr, wdata, rdata;
   logic        ren, wen, ready, valid, err;
   logic [3:0]  mask;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   int n_assert = 0;
   int n_fail   = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY), .BASE_ADDR(32'h0)) dut (
      .i_clk(clk), .i_rst(rst), .i_dmem_addr(addr), .i_dmem_ren(ren), .i_dmem_wen(wen),
      .i_dmem_wdata(wdata), .i_dmem_mask(mask), .o_dmem_ready(ready), .o_dmem_valid(valid),
      .o_dmem_rdata(rdata), .o_dmem_err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic req(input string tag, input logic [31:0] a, input logic r, input logic w,
                      input logic [31:0] wd, input logic [3:0] m,
                      input logic [31:0] exp_rdata, input logic exp_err);
      exp_t e;
      int   n;
      bit   got;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb.push_back(e);
      @(negedge clk);
      addr = a; ren = r; wen = w; wdata = wd; mask = m;
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      @(posedge clk);
      #1 ren = 1'b0; wen = 1'b0;
      n = 0; got = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (valid) begin
            got = 1'b1;
            n   = i;
         end
      end
      chk({tag, "_latency"}, 32'(n), 32'(LATENCY));
      e = sb.pop_front();
      if (got) begin
         chk({tag, "_rdata"}, rdata, e.rdata);
         chk({tag, "_err"}, 32'(err), 32'(e.err));
      end
      @(negedge clk);
      chk({tag, "_valid_drop"}, 32'(valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; addr = 32'h0; ren = 1'b0; wen = 1'b0; wdata = 32'h0; mask = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_err",   32'(err), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("ready_after_rst", 32'(ready), 32'd1);
      chk("idle_valid", 32'(valid), 32'd0);

      req("sw10",   32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
      req("lw10",   32'h10, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0);
      req("sb10",   32'h10, 1'b0, 1'b1, 32'h00AB0000, 4'b0100, 32'h0, 1'b0);
      req("lw10b",  32'h10, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hDEABBEEF, 1'b0);
      req("lh10",   32'h10, 1'b1, 1'b0, 32'h0,        4'b1100, 32'hDEAB0000, 1'b0);
      req("lm0",    32'h10, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0, 1'b0);
      req("sw0",    32'h00, 1'b0, 1'b1, 32'h12345678, 4'b1111, 32'h0, 1'b0);
      req("oob_sw", 32'(4 * DEPTH), 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
      req("oob_lw", 32'(4 * DEPTH), 1'b1, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b1);
      req("rw0",    32'h00, 1'b1, 1'b1, 32'h0,        4'b1111, 32'h0, 1'b1);
      req("lw0",    32'h00, 1'b1, 1'b0, 32'h0,        4'b1111, 32'h12345678, 1'b0);

      // Write to 0x20 aborted by reset while in WAIT.
      req("sw20",   32'h20, 1'b0, 1'b1, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
      @(negedge clk);
      addr = 32'h20; ren = 1'b0; wen = 1'b1; wdata = 32'h11111111; mask = 4'b1111;
      @(posedge clk);
      #1 wen = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_ready", 32'(ready), 32'd0);
      @(negedge clk);
      chk("abort_valid2", 32'(valid), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("abort_ready_back", 32'(ready), 32'd1);
      chk("abort_valid3", 32'(valid), 32'd0);
      req("lw20",   32'h20, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
      req("lw12",   32'h12, 1'b1, 1'b0, 32'h0,        4'b1111, 32'h0, 1'b1);
`else
      req("lw12",   32'h12, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hDEABBEEF, 1'b0);
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the storage array; power of two, at least 4.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response; allowed range 1..15.
REQ-003 Parameter BASE_ADDR, default 32'h00000000: byte address of word 0; word-aligned.
REQ-004 Port i_clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 Port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port i_dmem_addr, input, 32 bits: request byte address from the hart.
REQ-007 Port i_dmem_ren, input, 1 bit: read request.
REQ-008 Port i_dmem_wen, input, 1 bit: write request.
REQ-009 Port i_dmem_wdata, input, 32 bits: write data, byte-lane aligned.
REQ-010 Port i_dmem_mask, input, 4 bits: byte-lane enables; bit n selects bits [8n+7:8n].
REQ-011 Port o_dmem_ready, output, 1 bit: responder can accept a request this cycle.
REQ-012 Port o_dmem_valid, output, 1 bit: one-cycle response strobe.
REQ-013 Port o_dmem_rdata, output, 32 bits: read data, valid only while o_dmem_valid is high.
REQ-014 Port o_dmem_err, output, 1 bit: error qualifier, valid only while o_dmem_valid is high.

Function
REQ-015 State machine SHALL have three states: IDLE, WAIT, RESP; o_dmem_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, if ren or wen is high at a rising edge, the block SHALL accept the request: latch addr, ren, wen, wdata and mask; load the latency counter with LATENCY-1; move to WAIT, or directly to RESP when LATENCY=1.
REQ-017 Request inputs sampled outside IDLE SHALL be ignored; the hart holds its request until it sees ready.
REQ-018 WAIT SHALL decrement the counter each cycle and move to RESP when the counter reaches 0.
REQ-019 For a request accepted at edge T, o_dmem_valid SHALL be high for exactly the one cycle following edge T+LATENCY-1.
REQ-020 RESP SHALL last one cycle, then return to IDLE, so back-to-back requests are spaced LATENCY+1 cycles apart.
REQ-021 Word index SHALL equal (addr - BASE_ADDR) >> 2, using 32-bit unsigned wrap.
REQ-022 An index greater than or equal to DEPTH_WORDS SHALL produce a response with err=1 and rdata=0, and SHALL perform no write.
REQ-023 A request with ren and wen both high SHALL be accepted and produce err=1, rdata=0, and no write.
REQ-024 A read response SHALL drive rdata from array[index] for mask lanes set and 0 for lanes clear; a mask of 0 SHALL return 0 with err=0.
REQ-025 A write SHALL update only the masked lanes of array[index] at the edge that ends RESP; rdata SHALL be 0 on a write response.
REQ-026 A read issued after a write response SHALL observe the written data; there are no concurrent accesses.
REQ-027 Outputs SHALL be registered; there SHALL be no combinational path from request inputs to any output.

Reset
REQ-028 While i_rst is high, the block SHALL be in IDLE with o_dmem_ready=0, o_dmem_valid=0, o_dmem_rdata=0, o_dmem_err=0, and the counter at 0.
REQ-029 o_dmem_ready SHALL rise on the first rising edge after i_rst deasserts.
REQ-030 Reset during WAIT or RESP SHALL abort the transaction immediately: no response is produced and a pending write is discarded.
REQ-031 Array contents SHALL NOT be reset.

Configuration
REQ-032 Macro DMEM_RESPONDER_ALIGN_CHECK_EN, when defined, SHALL make a misaligned access produce err=1, rdata=0 and no write; misaligned means addr[1:0]!=0, or a mask inconsistent with a byte, halfword or word access at addr[1:0].
REQ-033 When DMEM_RESPONDER_ALIGN_CHECK_EN is undefined, addr[1:0] SHALL be ignored and any mask SHALL be accepted.

Verification
REQ-034 Reset then idle -> ready=1 after the first edge with rst low; valid, err and rdata all 0.
REQ-035 LATENCY=2, sw 0xDEADBEEF to 0x10 with mask 1111, then lw 0x10 with mask 1111 -> valid two cycles after each acceptance; read rdata=0xDEADBEEF, err=0.
REQ-036 sb with wdata 0x00AB0000 and mask 0100 to 0x10, then lw 0x10 -> rdata=0xDEABBEEF; then lh with mask 1100 -> rdata=0xDEAB0000.
REQ-037 Address BASE_ADDR+4*DEPTH_WORDS, and separately ren=wen=1 -> err=1, rdata=0; a subsequent lw of word 0 shows the value unchanged.
REQ-038 Assert i_rst during WAIT of a write to 0x20 -> no valid pulse; a later read of 0x20 returns the pre-write value.
REQ-039 With DMEM_RESPONDER_ALIGN_CHECK_EN defined, addr 0x12 with mask 1111 -> err=1; with the macro undefined, the same access -> err=0 and word 0x10 is accessed.
